// File: rtl/cart_dl_writer.sv
// Cartridge download write stage: queues HPS ioctl words in a small FIFO, writes them to
// SDRAM over a req/ack handshake, and tracks ROM size and the header checksum in passing.
module cart_dl_writer #(
  parameter int FIFO_AW = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cart_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic [23:0] sdram_addr,
  output logic [15:0] sdram_din,
  output logic        sdram_we,
  input  logic        sdram_ack,
  output logic        busy,
  output logic        dl_done,
  output logic [24:0] rom_bytes,
  output logic [7:0]  hdr_chk,
  output logic        hdr_chk_ok,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_WAIT = CNT_FULL - CNT_ONE;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t               state, state_nx;
  logic [39:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]   wptr, rptr;
  logic [FIFO_AW:0]     count, count_nx;
  logic                 load, pop;
  logic                 push, push_ok, full, empty;
  logic                 cart_d, start, fall;
  logic                 done_armed, done_armed_nx, done_fire;
  logic [24:0]          rom_bytes_nx, rom_base, addr_plus2;
  logic [7:0]           chk_nx, chk_base, exp_nx, hdr_exp;
  logic                 seen_nx, hdr_seen, ovf_nx;
  logic                 in_hdr_words, at_14c;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push    = cart_download & ioctl_wr;
  assign push_ok = push & ~full;
  assign start   = cart_download & ~cart_d;
  assign fall    = ~cart_download & cart_d;
  assign busy    = ~empty | (state == REQ);
  assign sdram_we = (state == REQ);

  // Write FSM: pick up the FIFO head in IDLE, hold the request until acknowledged.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load     = 1'b1;
          state_nx = REQ;
        end else begin
          state_nx = IDLE;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          pop      = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Occupancy after this edge; ioctl_wait is derived from it so one slot stays spare.
  always_comb begin
    count_nx = count;
    case ({push_ok, pop})
      2'b10:   count_nx = count + CNT_ONE;
      2'b01:   count_nx = count - CNT_ONE;
      default: count_nx = count;
    endcase
  end

  // FSM state, FIFO pointers, back-pressure and SDRAM request registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      ioctl_wait <= 1'b0;
      sdram_addr <= 24'h000000;
      sdram_din  <= 16'h0000;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      ioctl_wait <= (count_nx >= CNT_WAIT);
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop)     rptr <= rptr + PTR_ONE;
      if (load) begin
        sdram_addr <= mem[rptr][39:16];
        sdram_din  <= mem[rptr][15:0];
      end
    end
  end

  // FIFO storage; entries are {word address, data}.
  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem[wptr] <= {ioctl_addr[24:1], ioctl_dout};
    end
  end

  assign addr_plus2   = ioctl_addr + 25'd2;
  assign in_hdr_words = (ioctl_addr[24:12] == 13'd0) &&
                        (ioctl_addr[11:0] >= 12'h134) && (ioctl_addr[11:0] <= 12'h14A);
  assign at_14c       = (ioctl_addr[24:12] == 13'd0) && (ioctl_addr[11:0] == 12'h14C);

  // Statistics next-state: a download start clears first, then the same-cycle push applies.
  always_comb begin
    rom_base = start ? 25'd0 : rom_bytes;
    chk_base = start ? 8'h00 : hdr_chk;
    rom_bytes_nx = rom_base;
    chk_nx       = chk_base;
    exp_nx       = start ? 8'h00 : hdr_exp;
    seen_nx      = start ? 1'b0 : hdr_seen;
    ovf_nx       = (start ? 1'b0 : overflow) | (push & full);
    if (push_ok) begin
      if (addr_plus2 > rom_base) begin
        rom_bytes_nx = addr_plus2;
      end else begin
        rom_bytes_nx = rom_base;
      end
      if (in_hdr_words) begin
        chk_nx = chk_base - ioctl_dout[7:0] - ioctl_dout[15:8] - 8'd2;
      end else if (at_14c) begin
        chk_nx  = chk_base - ioctl_dout[7:0] - 8'd1;
        exp_nx  = ioctl_dout[15:8];
        seen_nx = 1'b1;
      end else begin
        chk_nx = chk_base;
      end
    end else begin
      rom_bytes_nx = rom_base;
    end
  end

  // Done arming: a restart discards a done still pending from the previous download.
  always_comb begin
    done_fire = done_armed & ~start & empty & (state == IDLE);
    if (start) begin
      done_armed_nx = 1'b0;
    end else if (fall) begin
      done_armed_nx = 1'b1;
    end else if (done_fire) begin
      done_armed_nx = 1'b0;
    end else begin
      done_armed_nx = done_armed;
    end
  end

  // Statistics, sticky overflow and download done registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cart_d     <= 1'b0;
      done_armed <= 1'b0;
      dl_done    <= 1'b0;
      rom_bytes  <= 25'd0;
      hdr_chk    <= 8'h00;
      hdr_exp    <= 8'h00;
      hdr_seen   <= 1'b0;
      hdr_chk_ok <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      cart_d     <= cart_download;
      done_armed <= done_armed_nx;
      dl_done    <= done_fire;
      rom_bytes  <= rom_bytes_nx;
      hdr_chk    <= chk_nx;
      hdr_exp    <= exp_nx;
      hdr_seen   <= seen_nx;
      hdr_chk_ok <= (chk_nx == exp_nx) && seen_nx;
      overflow   <= ovf_nx;
    end
  end

endmodule

// File: doc/cart_dl_writer.md
# cart_dl_writer

Download-side write stage for the cartridge path. It accepts 16-bit ROM words from the HPS ioctl stream during `cart_download` and buffers them in a small FIFO. It issues word writes to the SDRAM controller over a request/acknowledge handshake, and back-pressures the stream through `ioctl_wait`. While the data passes through, it measures the ROM image size and verifies the cartridge header checksum (0x134–0x14D), so the cart and mapper logic see a fully written ROM plus a validity flag when the download ends.

## Interface
Parameters:
- `FIFO_AW`, default 2: FIFO depth is 2^FIFO_AW entries (default 4). Minimum value is 2.

Ports:
- `clk_sys`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cart_download`  in  1  high for the whole cart ROM download.
- `ioctl_wr`  in  1  one-cycle strobe: `ioctl_addr`/`ioctl_dout` are valid.
- `ioctl_addr`  in  25  byte address; always even.
- `ioctl_dout`  in  16  data word: [7:0] is the byte at addr, [15:8] is the byte at addr+1.
- `ioctl_wait`  out  1  stall request to the HPS; registered.
- `sdram_addr`  out  24  word address, equal to `ioctl_addr[24:1]`.
- `sdram_din`  out  16  write data.
- `sdram_we`  out  1  write request; held high until acknowledged.
- `sdram_ack`  in  1  one-cycle completion from the SDRAM controller.
- `busy`  out  1  FIFO is non-empty or a write is outstanding.
- `dl_done`  out  1  one-cycle pulse: the download has ended and everything is written.
- `rom_bytes`  out  25  highest written `ioctl_addr` + 2.
- `hdr_chk`  out  8  running header checksum.
- `hdr_chk_ok`  out  1  computed checksum equals byte 0x14D; valid when `dl_done` pulses.
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full.

## Operation
- **Push.**
  - A word is pushed when `cart_download & ioctl_wr`. An entry is {addr[24:1], data}.
  - If the FIFO is full when a push arrives, the word is dropped and `overflow` is set.
  - `ioctl_wr` while `cart_download` is low is ignored.
- **Back-pressure.** `ioctl_wait` is registered from the next-state count: it is 1 when the count is ≥ DEPTH−1. This leaves one spare slot for a write that arrives in the same cycle `ioctl_wait` rises.
- **Write FSM.** Two states, IDLE and REQ.
  - IDLE: if the FIFO is non-empty, load `sdram_addr`/`sdram_din` from the FIFO head and go to REQ.
  - REQ: `sdram_we` = 1 and address/data are held stable. When `sdram_ack` = 1: pop the FIFO and return to IDLE.
  - `sdram_ack` seen in IDLE is ignored.
- **Simultaneous events.** A push and a pop in the same cycle leave the count unchanged. Pushing into an empty FIFO while in IDLE does not bypass the FIFO.
- **Size.** On every accepted push, `rom_bytes` = max(`rom_bytes`, `ioctl_addr`+2).
- **Checksum.** Only pushes with `ioctl_addr[24:12]` == 0 contribute.
  - For an accepted push at address a, in 0x134 ≤ a ≤ 0x14A: `hdr_chk` ← `hdr_chk` − lo − hi − 2, computed mod 256.
  - At a = 0x14C: `hdr_chk` ← `hdr_chk` − lo − 1. Byte hi (0x14D) is latched as the expected value.
  - `hdr_chk_ok` = (`hdr_chk` == expected) and the 0x14C word was received.
- **Start.** A rising edge of `cart_download` clears `rom_bytes`, `hdr_chk`, the expected value, the 0x14C-seen flag, `overflow`, and any pending done.
  - FIFO contents are not flushed; leftover entries keep draining.
- **End.** A falling edge of `cart_download` arms done. `dl_done` pulses for one cycle on the first cycle where done is armed, the FIFO is empty, and the FSM is in IDLE. It pulses exactly once per download.

## Timing
- **Reset values.** Under `reset`, asynchronously:
  - `ioctl_wait` = 0, `sdram_we` = 0, `sdram_addr` = 0, `sdram_din` = 0.
  - `busy` = 0, `dl_done` = 0, `rom_bytes` = 0, `hdr_chk` = 0, `hdr_chk_ok` = 0, `overflow` = 0.
  - FIFO empty, FSM in IDLE.
- **Reset during REQ.** `sdram_we` drops immediately and the write is abandoned.
- **Latency.** A push sampled at edge N gives `sdram_we` = 1 after edge N+1, with the matching address and data.
- **Ack turnaround.** An ack sampled at edge M gives `sdram_we` = 0 after M. The earliest next request is after edge M+1, so throughput is at most 1 word per 2 cycles.
- **Stat updates.** `hdr_chk` and `rom_bytes` update one cycle after the push edge.
- **Done.** `dl_done` comes at least 1 cycle after the falling edge of `cart_download`.
- **Busy.** `busy` is combinational from count and state.

## Test plan
- **Single word.** Push addr 0x000100, data 0xC300, ack 3 cycles after request → `sdram_addr` = 0x000080, `sdram_din` = 0xC300, `sdram_we` high for exactly 4 cycles, FIFO then empty.
- **Back-pressure.** 6 back-to-back pushes, `sdram_ack` held low → `ioctl_wait` = 1 after the 3rd push, the 4th push accepted, the 5th dropped, `overflow` = 1. Release ack every 2nd cycle → 4 writes complete in order.
- **Checksum.** Download a 32 KB image with a valid header (e.g. 0x14D = 0xE7 for the computed sum) → `hdr_chk_ok` = 1 and `rom_bytes` = 0x8000 at `dl_done`. Corrupt byte 0x140 → `hdr_chk_ok` = 0.
- **Drain.** Deassert `cart_download` with 3 entries still queued → `dl_done` pulses once, 1 cycle after the final ack is consumed. No pulse occurs before that.
- **Reset mid-write.** Assert `reset` while in REQ → `sdram_we` goes low without waiting for a clock edge and all outputs read zero. After release, a new download works normally.
- **Restart.** Raise `cart_download` again with 1 entry still pending → the stats clear, the pending entry is still written, and no `dl_done` pulse comes from the old download.
